exmem_arbiter: RTL and testbench

Two-requester arbiter in front of the exmem memory slave in the user project area. It shares the single exmem request port between requester 0 (instruction/prefetch side) and requester 1 (data/DMA side). It grants one owner per transaction and passes that owner's signals through to exmem. It holds the grant until ack and inserts a turnaround cycle between transactions. It aborts hung transactions with an error pulse and then drains the slave for a fixed time.

---
 rtl/exmem_pkg.sv | 28 ++
 rtl/rr_pick2.sv | 27 ++
 rtl/exmem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_exmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exmem_pkg.sv
// Shared definitions for the exmem arbiter slice.
// Provides the arbiter FSM encoding, the exmem address base, request field
// widths and the packed request payload that is muxed onto the slave port.
package exmem_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [ADR_W-1:0] EXMEM_BASE = 32'h3800_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // One requester's view of the slave request port.
  typedef struct packed {
    logic             valid;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
    logic [ADR_W-1:0] adr;
  } exmem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin against the last owner, or
// fixed priority to requester 0 when fixed_i is set.
// Ports:
//   req_i[1:0] request vector (bit n = requester n)
//   last_i     requester that owned the previous transaction
//   fixed_i    1 = requester 0 always wins a tie
//   gnt_o      some requester is asking
//   gnt_id_o   index of the chosen requester (valid when gnt_o)
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic       gnt_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_o    = |req_i;
    gnt_id_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_id_o = fixed_i ? 1'b0 : ~last_i;
    end else begin
      gnt_id_o = req_i[1];
    end
  end

endmodule

// File: rtl/exmem_arbiter.sv
// Two-requester arbiter in front of the exmem slave. Grants one owner per
// transaction, passes its request straight through to the slave, routes the
// slave ack/data back to the owner only, inserts a one-cycle turnaround and
// aborts hung transactions with an error pulse followed by a drain period.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   m0_* / m1_*             requester ports (valid/we/sel/dat/adr in,
//                           ack/err/dat out)
//   s_*                     exmem slave port
//   busy                    registered, high whenever the arbiter is not idle
//   owner                   registered, current or last granted requester
module exmem_arbiter
  import exmem_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned DRAIN_CYC  = 12,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_valid,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic          busy_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          err_c;
  logic          pick_gnt, pick_id;
  logic          in_grant;
  exmem_req_t    m0_req, m1_req, own_req;

  assign m0_req  = '{valid: m0_valid, we: m0_we, sel: m0_sel, dat: m0_dat_i, adr: m0_adr_i};
  assign m1_req  = '{valid: m1_valid, we: m1_we, sel: m1_sel, dat: m1_dat_i, adr: m1_adr_i};
  assign own_req = owner_q ? m1_req : m0_req;
  assign in_grant = (state_q == GRANT);

  rr_pick2 u_pick (
    .req_i    ({m1_valid, m0_valid}),
    .last_i   (rr_last_q),
    .fixed_i  (FIXED_PRIO != 0),
    .gnt_o    (pick_gnt),
    .gnt_id_o (pick_id)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Next-state logic. In GRANT an ack beats both abandon and timeout.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    err_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_gnt) begin
          owner_d = pick_id;
          tcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (s_ack_i) begin
          rr_last_d = owner_q;
          state_d   = TURN;
        end else if (!own_req.valid) begin
          // Owner walked away mid-transaction: no err, just flush the slave.
          rr_last_d = owner_q;
          dcnt_d    = '0;
          state_d   = DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_c     = 1'b1;
          rr_last_d = owner_q;
          dcnt_d    = '0;
          state_d   = DRAIN;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (dcnt_q == DW'(DRAIN_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave passthrough and response routing; everything is zero outside GRANT,
  // so acks seen during TURN/DRAIN/IDLE never reach a requester.
  always_comb begin
    s_valid  = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_dat_o  = '0;
    s_adr_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    if (in_grant) begin
      s_valid = own_req.valid;
      s_we    = own_req.we;
      s_sel   = own_req.sel;
      s_dat_o = own_req.dat;
      s_adr_o = own_req.adr;
      if (owner_q) begin
        m1_ack_o = s_ack_i;
        m1_err_o = err_c;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack_o = s_ack_i;
        m0_err_o = err_c;
        m0_dat_o = s_dat_i;
      end
    end
  end

  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_exmem_arbiter.sv
// Bench for exmem_arbiter. Two instances (round-robin and fixed priority)
// are driven from per-cycle requester/slave models; a transaction-level
// reference model predicts every output each cycle, and directed scenarios
// pin latencies, data and error timing with hand-computed constants.
module tb_exmem_arbiter;
  import exmem_pkg::*;

  localparam int ND  = 2;
  localparam int TMO = 32;
  localparam int DRN = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0]             rst_s;
  logic [ND-1:0][1:0]        mv, mwe, mack, merr;
  logic [ND-1:0][1:0][3:0]   msel;
  logic [ND-1:0][1:0][31:0]  mwd, madr, mrd;
  logic [ND-1:0]             sv, swe, sack, busy_s, own_s;
  logic [ND-1:0][3:0]        ssel;
  logic [ND-1:0][31:0]       swd, sadr, srd;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    exmem_arbiter #(.TIMEOUT(TMO), .DRAIN_CYC(DRN), .FIXED_PRIO(g)) u_dut (
      .wb_clk_i (clk),        .wb_rst_i (rst_s[g]),
      .m0_valid (mv[g][0]),   .m0_we    (mwe[g][0]),  .m0_sel   (msel[g][0]),
      .m0_dat_i (mwd[g][0]),  .m0_adr_i (madr[g][0]), .m0_ack_o (mack[g][0]),
      .m0_err_o (merr[g][0]), .m0_dat_o (mrd[g][0]),
      .m1_valid (mv[g][1]),   .m1_we    (mwe[g][1]),  .m1_sel   (msel[g][1]),
      .m1_dat_i (mwd[g][1]),  .m1_adr_i (madr[g][1]), .m1_ack_o (mack[g][1]),
      .m1_err_o (merr[g][1]), .m1_dat_o (mrd[g][1]),
      .s_valid  (sv[g]),      .s_we     (swe[g]),     .s_sel    (ssel[g]),
      .s_dat_o  (swd[g]),     .s_adr_o  (sadr[g]),    .s_ack_i  (sack[g]),
      .s_dat_i  (srd[g]),     .busy     (busy_s[g]),  .owner    (own_s[g])
    );
  end

  // Requester intent (-1 = request forever), slave behaviour, model state.
  int          want [ND][2];
  logic [31:0] r_adr [ND][2];
  logic [31:0] r_dat [ND][2];
  logic        r_we [ND][2];
  logic [3:0]  r_sel [ND][2];
  bit          rst_req [ND];
  int          lat [ND];
  bit          dead [ND];
  bit          spur [ND];
  int          scnt [ND];
  int          cur [ND];
  int          age [ND];
  int          hold [ND];
  int          last [ND];
  logic        e_own [ND];
  logic        e_busy [ND];
  bit          model_ok [ND];
  int          cyc, n_chk, n_fail;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'h0F0F_A5A5;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, answer as slave, compare, advance model.
  task automatic step();
    logic        exp_sv, exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wd, exp_adr;
    logic [1:0]  exp_ack, exp_err;
    logic [31:0] exp_rd [2];
    int          c, pick;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      rst_s[d] = rst_req[d];
      for (int r = 0; r < 2; r++) begin
        mv[d][r]   = (want[d][r] != 0);
        mwe[d][r]  = r_we[d][r];
        msel[d][r] = r_sel[d][r];
        mwd[d][r]  = r_dat[d][r];
        madr[d][r] = r_adr[d][r];
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      logic a;
      a = sv[d] && !dead[d] && (scnt[d] >= lat[d]);
      if (spur[d] && !sv[d]) a = 1'b1;
      sack[d] = a;
      srd[d]  = a ? rdat(sadr[d]) : 32'h0;
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      if (model_ok[d]) begin
        exp_sv = 1'b0; exp_we = 1'b0; exp_sel = '0; exp_wd = '0; exp_adr = '0;
        exp_ack = '0; exp_err = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        if (cur[d] >= 0) begin
          c = cur[d];
          exp_sv     = mv[d][c];
          exp_we     = mwe[d][c];
          exp_sel    = msel[d][c];
          exp_wd     = mwd[d][c];
          exp_adr    = madr[d][c];
          exp_ack[c] = sack[d];
          exp_rd[c]  = srd[d];
          exp_err[c] = !sack[d] && mv[d][c] && (age[d] == TMO - 1);
        end
        chk($sformatf("d%0d s_valid", d), sv[d], exp_sv);
        chk($sformatf("d%0d s_we", d), swe[d], exp_we);
        chk($sformatf("d%0d s_sel", d), ssel[d], exp_sel);
        chk($sformatf("d%0d s_dat_o", d), swd[d], exp_wd);
        chk($sformatf("d%0d s_adr_o", d), sadr[d], exp_adr);
        for (int r = 0; r < 2; r++) begin
          chk($sformatf("d%0d m%0d_ack_o", d, r), mack[d][r], exp_ack[r]);
          chk($sformatf("d%0d m%0d_err_o", d, r), merr[d][r], exp_err[r]);
          chk($sformatf("d%0d m%0d_dat_o", d, r), mrd[d][r], exp_rd[r]);
        end
        chk($sformatf("d%0d busy", d), busy_s[d], e_busy[d]);
        chk($sformatf("d%0d owner", d), own_s[d], e_own[d]);
      end
    end
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (mv[d][r] && (mack[d][r] || merr[d][r])) begin
          if (want[d][r] > 0) want[d][r]--;
          r_adr[d][r] = r_adr[d][r] + 32'd4;
        end
      end
      if (rst_s[d] || !sv[d] || sack[d]) scnt[d] = 0;
      else scnt[d]++;
      if (rst_s[d]) begin
        cur[d] = -1; hold[d] = 0; last[d] = 1; e_own[d] = 1'b0; e_busy[d] = 1'b0;
        model_ok[d] = 1'b1;
      end else begin
        if (cur[d] >= 0) begin
          c = cur[d];
          if (sack[d]) begin
            last[d] = c; cur[d] = -1; hold[d] = 1;
          end else if (!mv[d][c] || age[d] == TMO - 1) begin
            last[d] = c; cur[d] = -1; hold[d] = DRN;
          end else begin
            age[d]++;
          end
        end else if (hold[d] > 0) begin
          hold[d]--;
        end else begin
          if (mv[d][0] && mv[d][1]) pick = (d == 1) ? 0 : 1 - last[d];
          else if (mv[d][0]) pick = 0;
          else if (mv[d][1]) pick = 1;
          else pick = -1;
          if (pick >= 0) begin
            cur[d] = pick; age[d] = 0; e_own[d] = pick[0];
          end
        end
        e_busy[d] = (cur[d] >= 0) || (hold[d] > 0);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int d = 0; d < ND; d++) begin
      rst_req[d] = 1'b1; lat[d] = 1; dead[d] = 1'b0; spur[d] = 1'b0;
      for (int r = 0; r < 2; r++) begin
        want[d][r] = 0; r_adr[d][r] = EXMEM_BASE; r_we[d][r] = 1'b0;
        r_sel[d][r] = 4'hF; r_dat[d][r] = 32'h0;
      end
    end
    step();
    step();
    for (int d = 0; d < ND; d++) rst_req[d] = 1'b0;
  endtask

  initial begin
    int  t0, rise, ackc, n_ack, n_m1, first_own, rise1, ackc1, errc, dcnt, n_err;
    int  rises [2], acks [2], g [ND][2];
    logic [31:0] adr_seen, dat_seen, ackd [2];
    logic prev [ND];
    bit  drained, got;
    cyc = 0; n_chk = 0; n_fail = 0;
    for (int d = 0; d < ND; d++) begin
      model_ok[d] = 1'b0; scnt[d] = 0; cur[d] = -1; hold[d] = 0; last[d] = 1;
      age[d] = 0; e_own[d] = 1'b0; e_busy[d] = 1'b0;
    end

    // Reset state.
    do_reset();
    step();
    chk("rst busy", busy_s[0], 0);
    chk("rst owner", own_s[0], 0);
    chk("rst s_valid", sv[0], 0);
    chk("rst acks", {mack[0], merr[0], mack[1], merr[1]}, 0);

    // Single write from m0.
    do_reset();
    want[0][0] = 1; r_adr[0][0] = 32'h3800_0010; r_we[0][0] = 1'b1;
    r_dat[0][0] = 32'hDEAD_BEEF; lat[0] = 2;
    t0 = cyc; rise = -1; ackc = -1; n_ack = 0; n_m1 = 0; adr_seen = '0; dat_seen = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sv[0] && rise < 0) begin rise = cyc - 1; adr_seen = sadr[0]; dat_seen = swd[0]; end
      if (mack[0][0]) begin n_ack++; ackc = cyc - 1; end
      if (mack[0][1]) n_m1++;
    end
    chk("wr grant latency", rise - t0, 1);
    chk("wr ack latency", ackc - rise, 2);
    chk("wr ack count", n_ack, 1);
    chk("wr m1 ack count", n_m1, 0);
    chk("wr s_adr", adr_seen, 32'h3800_0010);
    chk("wr s_dat", dat_seen, 32'hDEAD_BEEF);

    // Simultaneous reads, round robin.
    do_reset();
    want[0][0] = 1; r_adr[0][0] = 32'h3800_0000;
    want[0][1] = 1; r_adr[0][1] = 32'h3800_0040;
    rises[0] = -1; rises[1] = -1; acks[0] = -1; acks[1] = -1; first_own = -1;
    ackd[0] = '0; ackd[1] = '0; prev[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sv[0] && !prev[0]) begin
        rises[own_s[0]] = cyc - 1;
        if (first_own < 0) first_own = int'(own_s[0]);
      end
      prev[0] = sv[0];
      for (int r = 0; r < 2; r++)
        if (mack[0][r]) begin acks[r] = cyc - 1; ackd[r] = mrd[0][r]; end
    end
    chk("rr first owner", first_own, 0);
    chk("rr m0 ack latency", acks[0] - rises[0], 1);
    chk("rr m1 grant gap", rises[1] - acks[0], 3);
    chk("rr m0 data", ackd[0], 32'h370F_A5A5);
    chk("rr m1 data", ackd[1], 32'h370F_A5E5);

    // Continuous requests: alternation vs starvation.
    do_reset();
    for (int d = 0; d < ND; d++) begin
      want[d][0] = -1; want[d][1] = -1; r_adr[d][1] = 32'h3800_0200;
      g[d][0] = 0; g[d][1] = 0; prev[d] = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        if (sv[d] && !prev[d]) g[d][own_s[d]]++;
        prev[d] = sv[d];
      end
    end
    chk("fixed m1 starved", g[1][1], 0);
    chk("fixed m0 served", g[1][0] >= 8, 1);
    chk("rr m0 served", g[0][0] >= 4, 1);
    chk("rr m1 served", g[0][1] >= 4, 1);
    chk("rr balanced", (g[0][0] - g[0][1] <= 1) && (g[0][1] - g[0][0] <= 1), 1);

    // Prefetch hit: zero-latency ack passes through in the first grant cycle.
    do_reset();
    want[0][0] = 1; r_adr[0][0] = 32'h3800_0000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (mack[0][0]) got = 1'b1;
    end
    chk("pf m0 done", got, 1);
    lat[0] = 0; want[0][1] = 1; r_adr[0][1] = 32'h3800_0004;
    rise = -1; ackc = -1; ackd[1] = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sv[0] && rise < 0) rise = cyc - 1;
      if (mack[0][1] && ackc < 0) begin ackc = cyc - 1; ackd[1] = mrd[0][1]; end
    end
    chk("pf ack in first grant", ackc - rise, 0);
    chk("pf ack seen", ackc >= 0, 1);
    chk("pf data", ackd[1], 32'h370F_A5A1);

    // Timeout, drain with spurious acks, then pending m1 is served.
    do_reset();
    dead[0] = 1'b1; want[0][0] = 1; r_adr[0][0] = 32'h3800_0020;
    rise = -1; errc = -1; n_err = 0; n_ack = 0; dcnt = 0; drained = 1'b0;
    rise1 = -1; ackc1 = 0; first_own = -1; ackd[1] = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sv[0] && rise < 0) begin
        rise = cyc - 1; want[0][1] = 1; r_adr[0][1] = 32'h3800_0080;
      end
      if (mack[0][0]) n_ack++;
      if (errc >= 0 && !drained) begin
        if (busy_s[0]) dcnt++;
        else begin drained = 1'b1; spur[0] = 1'b0; end
      end
      if (errc >= 0 && sv[0] && rise1 < 0) begin rise1 = cyc - 1; first_own = int'(own_s[0]); end
      if (mack[0][1]) begin ackc1++; ackd[1] = mrd[0][1]; end
      if (merr[0][0]) begin n_err++; errc = cyc - 1; dead[0] = 1'b0; spur[0] = 1'b1; end
    end
    chk("to err grant cycle", errc - rise + 1, 32);
    chk("to err pulses", n_err, 1);
    chk("to m0 ack count", n_ack, 0);
    chk("to drain cycles", dcnt, 12);
    chk("to m1 grant gap", rise1 - errc, 14);
    chk("to m1 owner", first_own, 1);
    chk("to m1 ack count", ackc1, 1);
    chk("to m1 data", ackd[1], 32'h370F_A525);

    // Reset in the middle of an m1 grant.
    do_reset();
    lat[0] = 5; want[0][1] = 1; r_adr[0][1] = 32'h3800_0100;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (sv[0]) got = 1'b1;
    end
    chk("mr granted", got, 1);
    step();
    rst_req[0] = 1'b1; want[0][0] = 0; want[0][1] = 0;
    step();
    chk("mr no ack in rst cycle", {mack[0], merr[0]}, 0);
    rst_req[0] = 1'b0;
    step();
    chk("mr s_valid", sv[0], 0);
    chk("mr busy", busy_s[0], 0);
    chk("mr owner", own_s[0], 0);
    chk("mr ack/err", {mack[0], merr[0]}, 0);
    want[0][0] = 1; r_adr[0][0] = 32'h3800_0300;
    want[0][1] = 1; r_adr[0][1] = 32'h3800_0400;
    rise = -1; adr_seen = '0; first_own = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sv[0] && rise < 0) begin rise = cyc - 1; adr_seen = sadr[0]; first_own = int'(own_s[0]); end
    end
    chk("mr tie owner", first_own, 0);
    chk("mr tie adr", adr_seen, 32'h3800_0300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
